pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter WIDTH, default 7, duty output width in bits; duty counts saturate at 2^WIDTH-1.
REQ-002 Parameter DVSR_FAST, default 10416, prescaler terminal count when sel_i=0 (960 Hz PWM frame at 10 MHz).
REQ-003 Parameter DVSR_SLOW, default 200000, prescaler terminal count when sel_i=1 (servo mode).
REQ-004 clk_i  input  1  single system clock, all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 pwm_i  input  1  asynchronous PWM waveform to be measured.
REQ-007 sel_i  input  1  prescaler select: 0 = DVSR_FAST, 1 = DVSR_SLOW.
REQ-008 duty_o  output  WIDTH  last measured high time in prescaler ticks.
REQ-009 period_o  output  8  last measured period in prescaler ticks, saturating at 255.
REQ-010 valid_o  output  1  one-cycle pulse when duty_o/period_o update.
REQ-011 timeout_o  output  1  level; no edge seen within 256 ticks.

Function
REQ-012 pwm_i SHALL pass a 2-flop synchronizer; rise/fall SHALL be detected from the 2nd flop against a 3rd delayed flop.
REQ-013 Prescaler SHALL count 0..DVSR (per sel_i), emit tick for one cycle at DVSR, wrap to 0, and clear to 0 on every accepted rising edge.
REQ-014 FSM states: IDLE, HIGH, LOW; reset state IDLE.
REQ-015 IDLE: on rise -> HIGH, clear hcnt and pcnt; ticks ignored; falls ignored.
REQ-016 HIGH: each tick increments hcnt (saturate 2^WIDTH-1) and pcnt (saturate 255); on fall -> LOW.
REQ-017 LOW: each tick increments pcnt (saturating); on rise -> latch duty_o=hcnt, period_o=pcnt, pulse valid_o, clear counters and prescaler, -> HIGH.
REQ-018 Latency: rise on pwm_i sampled at clock edge k SHALL produce valid_o high in the cycle after edge k+3, for exactly one cycle.
REQ-019 Timeout: tick arriving while pcnt=255 in HIGH -> duty_o=2^WIDTH-1, period_o=0, valid_o pulse, timeout_o=1, -> IDLE; same in LOW -> duty_o=0, period_o=0, valid_o pulse, timeout_o=1, -> IDLE.
REQ-020 timeout_o SHALL clear on the next accepted rise in IDLE.
REQ-021 sel_i change (compared to registered copy) SHALL force IDLE, clear counters and prescaler, hold duty_o/period_o/timeout_o, no valid_o.
REQ-022 Simultaneous events priority: sel_i change > edge > tick; a tick coincident with an edge SHALL not be counted.
REQ-023 A high pulse shorter than one tick SHALL yield duty_o=0 with normal period_o.

Reset
REQ-024 rst_i asserted SHALL immediately set duty_o=0, period_o=0, valid_o=0, timeout_o=0, state IDLE, all counters and synchronizer flops 0.
REQ-025 Reset mid-measurement SHALL discard the partial measurement; first valid_o after release requires two accepted rises.

Structure
REQ-026 Package pwm_pkg SHALL hold DVSR_FAST/DVSR_SLOW defaults, period width (8), timeout limit (255) and the FSM state encoding, shared with the PWM generator.
REQ-027 One sub-module pwm_edge_sync (synchronizer + rise/fall detect) SHALL be instantiated; remainder flat.

Verification (DVSR_FAST=3, DVSR_SLOW=7 overrides: tick every 4 / 8 clocks)
REQ-028 Reset held 5 cycles, pwm_i toggling -> all outputs 0, no valid_o.
REQ-029 sel_i=0, pwm_i high 40 / low 88 clocks repeating -> after 2nd rise duty_o=10, period_o=32, single-cycle valid_o each frame.
REQ-030 sel_i=1, pwm_i high 40 / low 216 clocks -> duty_o=5, period_o=32.
REQ-031 pwm_i held high 1100 clocks after one rise (sel_i=0) -> timeout_o=1, duty_o=127, period_o=0; next rise clears timeout_o.
REQ-032 sel_i toggled mid-HIGH -> no valid_o for that frame, outputs held, next valid_o after two rises.
REQ-033 rst_i pulsed mid-HIGH -> outputs 0 asynchronously, IDLE; 2-clock high pulses -> duty_o=0, period_o per frame.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM capture block and the PWM generator:
// prescaler defaults, period counter width, timeout limit and FSM encoding.
package pwm_pkg;

  localparam int DVSR_FAST_DEF = 10416;
  localparam int DVSR_SLOW_DEF = 200000;
  localparam int PERIOD_W      = 8;

  localparam logic [PERIOD_W-1:0] TIMEOUT_LIMIT = 8'd255;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM input plus rise/fall detection.
// rise_pre is the combinational detect; rise/fall are the same detects one clock later.
module pwm_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  output logic rise_pre,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  assign rise_pre = sync_p1 & ~sync_p2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= pwm_i;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      // detect stage: 2nd flop against the delayed 3rd flop
      rise    <= sync_p1 & ~sync_p2;
      fall    <= ~sync_p1 & sync_p2;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM duty/period capture: prescaled tick counting of high time and period,
// with timeout on a stuck input and restart on prescaler selection change.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH     = 7,
  parameter int DVSR_FAST = DVSR_FAST_DEF,
  parameter int DVSR_SLOW = DVSR_SLOW_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pwm_i,
  input  logic                sel_i,
  output logic [WIDTH-1:0]    duty_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                valid_o,
  output logic                timeout_o
);

  localparam int DVSR_MAX = (DVSR_SLOW > DVSR_FAST) ? DVSR_SLOW : DVSR_FAST;
  localparam int PS_W     = $clog2(DVSR_MAX + 1);
  localparam logic [PS_W-1:0] PS_FAST = PS_W'(DVSR_FAST);
  localparam logic [PS_W-1:0] PS_SLOW = PS_W'(DVSR_SLOW);

  logic                rise_pre;
  logic                rise;
  logic                fall;
  logic                sel_q;
  logic                sel_chg;
  logic                tick;
  logic                rise_accept;
  logic [PS_W-1:0]     ps_cnt;
  logic [PS_W-1:0]     dvsr;
  logic [1:0]          state;
  logic [WIDTH-1:0]    hcnt;
  logic [PERIOD_W-1:0] pcnt;

  function automatic logic [WIDTH-1:0] sat_inc_duty(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  function automatic logic [PERIOD_W-1:0] sat_inc_period(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + PERIOD_W'(1);
  endfunction

  pwm_edge_sync u_edge_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pwm_i    (pwm_i),
    .rise_pre (rise_pre),
    .rise     (rise),
    .fall     (fall)
  );

  assign sel_chg = sel_i ^ sel_q;
  assign dvsr    = sel_q ? PS_SLOW : PS_FAST;
  assign tick    = (ps_cnt == dvsr);

  // The prescaler restarts on the early detect so the FSM, acting one clock
  // later, never sees a tick on the same edge as the rise it accepts.
  assign rise_accept = rise_pre & ((state != ST_HIGH) | fall) & ~sel_chg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ps_cnt <= '0;
    end else if (sel_chg || rise_accept || tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q     <= 1'b0;
      state     <= ST_IDLE;
      hcnt      <= '0;
      pcnt      <= '0;
      duty_o    <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      sel_q   <= sel_i;
      valid_o <= 1'b0;
      if (sel_chg) begin
        state <= ST_IDLE;
        hcnt  <= '0;
        pcnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state     <= ST_HIGH;
              hcnt      <= '0;
              pcnt      <= '0;
              timeout_o <= 1'b0;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              state <= ST_LOW;
            end else if (tick) begin
              if (pcnt == TIMEOUT_LIMIT) begin
                duty_o    <= '1;
                period_o  <= '0;
                valid_o   <= 1'b1;
                timeout_o <= 1'b1;
                hcnt      <= '0;
                pcnt      <= '0;
                state     <= ST_IDLE;
              end else begin
                hcnt <= sat_inc_duty(hcnt);
                pcnt <= sat_inc_period(pcnt);
              end
            end
          end
          ST_LOW: begin
            if (rise) begin
              duty_o   <= hcnt;
              period_o <= pcnt;
              valid_o  <= 1'b1;
              hcnt     <= '0;
              pcnt     <= '0;
              state    <= ST_HIGH;
            end else if (tick) begin
              if (pcnt == TIMEOUT_LIMIT) begin
                duty_o    <= '0;
                period_o  <= '0;
                valid_o   <= 1'b1;
                timeout_o <= 1'b1;
                hcnt      <= '0;
                pcnt      <= '0;
                state     <= ST_IDLE;
              end else begin
                pcnt <= sat_inc_period(pcnt);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture with fast/slow prescalers of 4/8 clocks per tick.
module tb_pwm_capture;

  logic       clk;
  logic       rst;
  logic       pwm;
  logic       sel;
  logic [6:0] duty;
  logic [7:0] period;
  logic       valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [6:0] duty;
    logic [7:0] period;
    logic       to;
    int         lat_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  pwm_capture #(
    .WIDTH     (7),
    .DVSR_FAST (3),
    .DVSR_SLOW (7)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pwm_i     (pwm),
    .sel_i     (sel),
    .duty_o    (duty),
    .period_o  (period),
    .valid_o   (valid),
    .timeout_o (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // lat=1: valid must appear in the cycle after the 4th edge following this negedge
  task automatic push_exp(input int d, input int p, input int t, input bit lat);
    exp_t e;
    e.duty    = 7'(d);
    e.period  = 8'(p);
    e.to      = 1'(t);
    e.lat_cyc = lat ? cyc + 4 : 0;
    exp_q.push_back(e);
  endtask

  task automatic drive_frame(input int hi, input int lo);
    pwm = 1'b1;
    repeat (hi) @(negedge clk);
    pwm = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("duty", 32'(duty), 32'(mon_e.duty));
        check("period", 32'(period), 32'(mon_e.period));
        check("timeout", 32'(timeout), 32'(mon_e.to));
        if (mon_e.lat_cyc != 0) check("latency", cyc, mon_e.lat_cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    pwm = 1'b0;
    sel = 1'b0;

    // reset held with pwm toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pwm = ~pwm;
      check("rst_duty", 32'(duty), 0);
      check("rst_period", 32'(period), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_timeout", 32'(timeout), 0);
    end
    pwm = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // fast mode: 40 high / 88 low
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push_exp(10, 32, 0, i == 1);
      drive_frame(40, 88);
    end

    // switch to slow mode while LOW: restart, outputs held
    sel = 1'b1;
    repeat (5) @(negedge clk);
    check("sel_hold_duty", 32'(duty), 10);
    check("sel_hold_period", 32'(period), 32);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push_exp(5, 32, 0, 0);
      drive_frame(40, 216);
    end

    // back to fast mode, then stuck high -> timeout in HIGH
    sel = 1'b0;
    repeat (5) @(negedge clk);
    check("sel_hold2_duty", 32'(duty), 5);
    check("sel_hold2_period", 32'(period), 32);
    push_exp(127, 0, 1, 0);
    drive_frame(1100, 50);
    check("to_high_level", 32'(timeout), 1);
    check("to_high_duty", 32'(duty), 127);
    check("to_high_period", 32'(period), 0);
    pwm = 1'b1;
    repeat (6) @(negedge clk);
    check("to_clear", 32'(timeout), 0);
    check("to_clear_duty_held", 32'(duty), 127);
    repeat (34) @(negedge clk);
    pwm = 1'b0;
    repeat (88) @(negedge clk);

    // sel toggled mid-HIGH: frame abandoned, next valid after two rises
    push_exp(10, 32, 0, 1);
    pwm = 1'b1;
    repeat (20) @(negedge clk);
    sel = 1'b1;
    repeat (5) @(negedge clk);
    check("midhigh_hold_duty", 32'(duty), 10);
    check("midhigh_hold_period", 32'(period), 32);
    repeat (15) @(negedge clk);
    pwm = 1'b0;
    repeat (216) @(negedge clk);
    drive_frame(40, 216);

    // reset pulse mid-HIGH
    push_exp(5, 32, 0, 0);
    pwm = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    pwm = 1'b0;
    sel = 1'b0;
    #1;
    check("async_rst_duty", 32'(duty), 0);
    check("async_rst_period", 32'(period), 0);
    check("async_rst_valid", 32'(valid), 0);
    check("async_rst_timeout", 32'(timeout), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // pulses shorter than one tick
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push_exp(0, 32, 0, i == 1);
      drive_frame(2, 126);
    end

    // stuck low -> timeout in LOW
    push_exp(0, 32, 0, 0);
    push_exp(0, 0, 1, 0);
    drive_frame(40, 1100);
    check("to_low_level", 32'(timeout), 1);
    check("to_low_duty", 32'(duty), 0);
    check("to_low_period", 32'(period), 0);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
